// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: op codes, FSM states, sizes.
package shift_pkg;

    localparam int WIDTH  = 32;
    localparam int STAGES = 5;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// One binary shifter stage: moves din by 1<<k positions in the direction selected by op.
module shift_stage
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       op,
    input  logic [2:0]       k,
    output logic [WIDTH-1:0] dout
);

    logic [4:0] sh;

    assign sh = 5'd1 << k;

    always_comb begin
        dout = din;
        case (op)
            SHIFT_SLL: dout = din << sh;
            SHIFT_SRL: dout = din >> sh;
            SHIFT_SRA: dout = $signed(din) >>> sh;
            SHIFT_ROL: dout = (din << sh) | (din >> (6'd32 - {1'b0, sh}));
            default:   dout = din;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that applies the 1/2/4/8/16 shift stages one per clock to an accumulator,
// with valid/ready on both the request and result sides.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] movement,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on valid, and a producer keeps valid/data steady until the transfer.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       amt_q, amt_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       k_q, k_d;
    logic [WIDTH-1:0] stage_out;
    logic             last_stage;
    logic             unused_movement;

    assign unused_movement = ^movement[WIDTH-1:5];

    shift_stage u_stage (
        .din  (acc_q),
        .op   (op_q),
        .k    (k_q),
        .dout (stage_out)
    );

    // With SKIP_ZERO the run ends as soon as no higher amount bit is left to apply.
    assign last_stage = (k_q == 3'd4) ||
                        (SKIP_ZERO && ((amt_q >> (k_q + 3'd1)) == 5'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            amt_q   <= '0;
            op_q    <= SHIFT_SLL;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            op_q    <= op_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        op_d    = op_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = a;
                    amt_d   = movement[4:0];
                    op_d    = op;
                    k_d     = 3'd0;
                    state_d = (SKIP_ZERO && (movement[4:0] == 5'd0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (amt_q[k_q]) begin
                    acc_d = stage_out;
                end
                k_d = k_q + 3'd1;
                if (last_stage) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = acc_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: one fixed-latency and one early-terminating instance.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] movement = '0;
    logic [1:0]  op = 2'b00;

    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic        out_ready0 = 1'b0, out_ready1 = 1'b0;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
    logic [31:0] out0, out1;

    logic        sel = 1'b0;
    logic        m_in_ready, m_out_valid, m_busy;
    logic [31:0] m_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign m_in_ready  = sel ? in_ready1  : in_ready0;
    assign m_out_valid = sel ? out_valid1 : out_valid0;
    assign m_busy      = sel ? busy1      : busy0;
    assign m_out       = sel ? out1       : out0;

    shift_seq_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .movement(movement), .op(op), .out_valid(out_valid0),
        .out_ready(out_ready0), .out(out0), .busy(busy0)
    );

    shift_seq_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .movement(movement), .op(op), .out_valid(out_valid1),
        .out_ready(out_ready1), .out(out1), .busy(busy1)
    );

    task automatic set_in_valid(input logic v);
        if (sel) in_valid1 = v; else in_valid0 = v;
    endtask

    task automatic set_out_ready(input logic v);
        if (sel) out_ready1 = v; else out_ready0 = v;
    endtask

    // Issue one request, wait for the result; cyc is the cycle of first out_valid
    // counting the accept cycle as 0. Leaves the result pending in DONE.
    task automatic issue(input logic [31:0] av, input logic [31:0] mv, input logic [1:0] opv,
                         output int cyc);
        int t;
        t = 0;
        while (!m_in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        a = av; movement = mv; op = opv;
        set_in_valid(1'b1);
        @(posedge clk); #1;
        set_in_valid(1'b0);
        a = ~av; movement = ~mv; op = ~opv;
        cyc = 1;
        while (!m_out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic release_result();
        set_out_ready(1'b1);
        @(posedge clk); #1;
        set_out_ready(1'b0);
    endtask

    task automatic expect_result(input string name, input logic [31:0] exp_out,
                                 input int exp_cyc, input int cyc);
        // kept as two separate inline checks per call site via this thin wrapper would be a
        // shared helper, so callers do their own comparisons instead
    endtask

    task automatic test_reset();
        sel = 1'b0;
        #2;
        n_checks++;
        if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready0); else n_pass++;
        n_checks++;
        if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid0); else n_pass++;
        n_checks++;
        if (out0 !== 32'h0) $display("FAIL reset_out got %h want 0", out0); else n_pass++;
        n_checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL reset_busy got %b%b want 00", busy0, busy1); else n_pass++;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sll31();
        int cyc;
        sel = 1'b0;
        issue(32'h0000_0001, 32'd31, 2'b00, cyc);
        n_checks++;
        if (cyc !== 6) $display("FAIL sll31_latency got %0d want 6", cyc); else n_pass++;
        n_checks++;
        if (m_out !== 32'h8000_0000) $display("FAIL sll31_out got %h want 80000000", m_out); else n_pass++;
        n_checks++;
        if (m_in_ready !== 1'b0 || m_busy !== 1'b1) $display("FAIL sll31_done_flags got rdy=%b busy=%b want 0 1", m_in_ready, m_busy); else n_pass++;
        release_result();
        n_checks++;
        if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) $display("FAIL sll31_cycle7 got rdy=%b vld=%b want 1 0", m_in_ready, m_out_valid); else n_pass++;
    endtask

    task automatic test_sra_srl();
        int cyc;
        sel = 1'b0;
        issue(32'h8000_00F0, 32'h0000_0024, 2'b10, cyc);
        n_checks++;
        if (m_out !== 32'hF800_000F) $display("FAIL sra_out got %h want f800000f", m_out); else n_pass++;
        release_result();
        issue(32'h8000_00F0, 32'h0000_0024, 2'b01, cyc);
        n_checks++;
        if (m_out !== 32'h0800_000F) $display("FAIL srl_out got %h want 0800000f", m_out); else n_pass++;
        release_result();
    endtask

    task automatic test_rol();
        int cyc;
        sel = 1'b0;
        issue(32'h1234_5678, 32'd8, 2'b11, cyc);
        n_checks++;
        if (m_out !== 32'h3456_7812) $display("FAIL rol8_out got %h want 34567812", m_out); else n_pass++;
        release_result();
        issue(32'h1234_5678, 32'd0, 2'b11, cyc);
        n_checks++;
        if (m_out !== 32'h1234_5678) $display("FAIL rol0_out got %h want 12345678", m_out); else n_pass++;
        n_checks++;
        if (cyc !== 6) $display("FAIL rol0_latency got %0d want 6", cyc); else n_pass++;
        release_result();
    endtask

    task automatic test_skip_zero();
        int cyc;
        logic [31:0] mvs [5];
        logic [31:0] exps [5];
        int          cycs [5];
        mvs = '{32'd0, 32'd1, 32'd16, 32'd5, 32'd31};
        exps = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_0000, 32'hFFFF_FFE0, 32'h8000_0000};
        cycs = '{1, 2, 6, 4, 6};
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(32'hFFFF_FFFF, mvs[i], 2'b00, cyc);
            n_checks++;
            if (cyc !== cycs[i]) $display("FAIL skip_latency mv=%0d got %0d want %0d", mvs[i], cyc, cycs[i]); else n_pass++;
            n_checks++;
            if (m_out !== exps[i]) $display("FAIL skip_out mv=%0d got %h want %h", mvs[i], m_out, exps[i]); else n_pass++;
            release_result();
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        sel = 1'b0;
        issue(32'h0000_0003, 32'd2, 2'b00, cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(32'hFFFF, 0);
            op = 2'($urandom_range(3, 0));
            movement = 32'($urandom_range(31, 1));
            in_valid0 = i[0];
            @(posedge clk); #1;
            if (out0 !== 32'h0000_000C || out_valid0 !== 1'b1 || in_ready0 !== 1'b0) bad++;
        end
        in_valid0 = 1'b0;
        n_checks++;
        if (bad !== 0) $display("FAIL bp_hold bad_cycles got %0d want 0", bad); else n_pass++;
        n_checks++;
        if (out0 !== 32'h0000_000C) $display("FAIL bp_deliver got %h want 0000000c", out0); else n_pass++;
        release_result();
        @(posedge clk); #1;
        n_checks++;
        if (busy0 !== 1'b0 || in_ready0 !== 1'b1) $display("FAIL bp_no_queue got busy=%b rdy=%b want 0 1", busy0, in_ready0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        sel = 1'b0;
        a = 32'h0000_000F; movement = 32'd1; op = 2'b00;
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0)
            $display("FAIL midrst_flags got vld=%b rdy=%b busy=%b want 0 1 0", out_valid0, in_ready0, busy0);
        else n_pass++;
        n_checks++;
        if (out0 !== 32'h0) $display("FAIL midrst_out got %h want 0", out0); else n_pass++;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'h0000_0100, 32'd4, 2'b01, cyc);
        n_checks++;
        if (out0 !== 32'h0000_0010 || cyc !== 6) $display("FAIL midrst_next got %h cyc=%0d want 00000010 cyc=6", out0, cyc); else n_pass++;
        release_result();
    endtask

    initial begin
        test_reset();
        test_sll31();
        test_sra_srl();
        test_rol();
        test_skip_zero();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
